// File: rtl/sev_seg_capture_pkg.sv
// Shared constants for the seven-segment capture block: hex segment table,
// bus bit positions, digit-select codes and the capture FSM state encoding.
package sev_seg_pkg;

  // Segment patterns {g,f,e,d,c,b,a}, active-high (bus is active-low)
  localparam logic [6:0] SEG_HEX_0 = 7'h3F;
  localparam logic [6:0] SEG_HEX_1 = 7'h06;
  localparam logic [6:0] SEG_HEX_2 = 7'h5B;
  localparam logic [6:0] SEG_HEX_3 = 7'h4F;
  localparam logic [6:0] SEG_HEX_4 = 7'h66;
  localparam logic [6:0] SEG_HEX_5 = 7'h6D;
  localparam logic [6:0] SEG_HEX_6 = 7'h7D;
  localparam logic [6:0] SEG_HEX_7 = 7'h07;
  localparam logic [6:0] SEG_HEX_8 = 7'h7F;
  localparam logic [6:0] SEG_HEX_9 = 7'h6F;
  localparam logic [6:0] SEG_HEX_A = 7'h77;
  localparam logic [6:0] SEG_HEX_B = 7'h7C;
  localparam logic [6:0] SEG_HEX_C = 7'h39;
  localparam logic [6:0] SEG_HEX_D = 7'h5E;
  localparam logic [6:0] SEG_HEX_E = 7'h79;
  localparam logic [6:0] SEG_HEX_F = 7'h71;

  localparam int BIT_DP = 7;

  localparam logic [1:0] EN_DIGIT0 = 2'b01;
  localparam logic [1:0] EN_DIGIT1 = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_HOLD   = 2'd2
  } state_t;

  function automatic logic en_is_valid(input logic [1:0] en);
    return (en == EN_DIGIT0) || (en == EN_DIGIT1);
  endfunction

endpackage

// File: rtl/sev_seg_capture_if.sv
// Frame output channel of the seven-segment capture block.
// Handshake: the source raises frame_valid with frame_data/frame_dp/decode_err
// stable and holds them until a rising clock edge where frame_valid & frame_ready;
// the sink may drive frame_ready at any time, independently of frame_valid.
interface sev_seg_capture_if;
  logic       frame_valid;
  logic       frame_ready;
  logic [7:0] frame_data;
  logic [1:0] frame_dp;
  logic [1:0] decode_err;

  modport master (
    output frame_valid,
    output frame_data,
    output frame_dp,
    output decode_err,
    input  frame_ready
  );

  modport slave (
    input  frame_valid,
    input  frame_data,
    input  frame_dp,
    input  decode_err,
    output frame_ready
  );
endinterface

// File: rtl/sev_seg_capture_decode.sv
// Combinational segment-pattern decoder: 7-bit active-high {g..a} pattern to
// hex nibble; patterns outside the hex table flag an error and yield nibble 0.
module sev_seg_decode
  import sev_seg_pkg::*;
(
  input  logic [6:0] i_pattern,
  output logic       o_err,
  output logic [3:0] o_nibble
);

  always_comb begin
    o_err    = 1'b0;
    o_nibble = 4'h0;
    case (i_pattern)
      SEG_HEX_0: o_nibble = 4'h0;
      SEG_HEX_1: o_nibble = 4'h1;
      SEG_HEX_2: o_nibble = 4'h2;
      SEG_HEX_3: o_nibble = 4'h3;
      SEG_HEX_4: o_nibble = 4'h4;
      SEG_HEX_5: o_nibble = 4'h5;
      SEG_HEX_6: o_nibble = 4'h6;
      SEG_HEX_7: o_nibble = 4'h7;
      SEG_HEX_8: o_nibble = 4'h8;
      SEG_HEX_9: o_nibble = 4'h9;
      SEG_HEX_A: o_nibble = 4'hA;
      SEG_HEX_B: o_nibble = 4'hB;
      SEG_HEX_C: o_nibble = 4'hC;
      SEG_HEX_D: o_nibble = 4'hD;
      SEG_HEX_E: o_nibble = 4'hE;
      SEG_HEX_F: o_nibble = 4'hF;
      default:   o_err    = 1'b1;
    endcase
  end

endmodule

// File: rtl/sev_seg_capture.sv
// Receive side of a multiplexed 2-digit seven-segment bus: waits for each digit
// to settle, decodes it and emits {digit_1,digit_0} frames over valid/ready.
// Optional macro SEV_SEG_CAP_ERRCNT_EN adds err_count (saturating decode-error count).
module sev_seg_capture
  import sev_seg_pkg::*;
#(
  parameter int SETTLE_CYCLES  = 4,
  parameter int TIMEOUT_CYCLES = 1024
)
(
  input  logic              clk_main,
  input  logic              reset_n,
  input  logic [7:0]        sev_seg_leds,
  input  logic [1:0]        led_enable,
  sev_seg_capture_if.master frame,
  output logic              overflow,
  output logic              link_lost,
`ifdef SEV_SEG_CAP_ERRCNT_EN
  output logic [7:0]        err_count,
`endif
  output state_t            dbg_state
);

  localparam logic [8:0]  SETTLE_N  = 9'(SETTLE_CYCLES);
  localparam logic [15:0] TIMEOUT_N = 16'(TIMEOUT_CYCLES);

  logic [7:0]  r_leds;
  logic [1:0]  r_en;
  state_t      r_state;
  state_t      w_state_nxt;
  logic [7:0]  r_settle_cnt;
  logic [1:0]  r_ref_en;
  logic [7:0]  r_ref_leds;
  logic [1:0]  r_got;
  logic [3:0]  r_nib0;
  logic [3:0]  r_nib1;
  logic [1:0]  r_derr;
  logic [1:0]  r_ddp;
  logic        r_valid;
  logic [7:0]  r_data;
  logic [1:0]  r_fdp;
  logic [1:0]  r_ferr;
  logic        r_overflow;
  logic [15:0] r_to_cnt;
  logic        r_link_lost;

  logic        w_en_valid;
  logic        w_changed;
  logic        w_capture;
  logic        w_restart;
  logic        w_cnt_inc;
  logic [6:0]  w_seg_pat;
  logic        w_dp_lit;
  logic        w_dec_err;
  logic [3:0]  w_dec_nib;
  logic        w_cap_d0;
  logic        w_cap_d1;
  logic [1:0]  w_got_nxt;
  logic        w_frame_done;
  logic        w_relink;
  logic [3:0]  w_nib0_new;
  logic [3:0]  w_nib1_new;

  // All decisions are made on this registered copy of the bus
  always_ff @(posedge clk_main or negedge reset_n) begin
    if (!reset_n) begin
      r_leds <= 8'h00;
      r_en   <= 2'b00;
    end else begin
      r_leds <= sev_seg_leds;
      r_en   <= led_enable;
    end
  end

  assign w_en_valid = en_is_valid(r_en);
  assign w_changed  = (r_en != r_ref_en) || (r_leds != r_ref_leds);
  assign w_seg_pat  = ~r_leds[6:0];
  assign w_dp_lit   = ~r_leds[BIT_DP];

  sev_seg_decode u_decode (
    .i_pattern (w_seg_pat),
    .o_err     (w_dec_err),
    .o_nibble  (w_dec_nib)
  );

  // r_settle_cnt holds how many consecutive cycles the current pattern has been seen
  always_comb begin
    w_state_nxt = r_state;
    w_capture   = 1'b0;
    w_restart   = 1'b0;
    w_cnt_inc   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_en_valid) begin
          w_state_nxt = ST_SETTLE;
          w_restart   = 1'b1;
        end
      end
      ST_SETTLE: begin
        if (!w_en_valid) begin
          w_state_nxt = ST_IDLE;
        end else if (w_changed) begin
          w_restart = 1'b1;
        end else if ({1'b0, r_settle_cnt} + 9'd1 >= SETTLE_N) begin
          w_state_nxt = ST_HOLD;
          w_capture   = 1'b1;
        end else begin
          w_cnt_inc = 1'b1;
        end
      end
      ST_HOLD: begin
        if (r_en != r_ref_en) begin
          if (w_en_valid) begin
            w_state_nxt = ST_SETTLE;
            w_restart   = 1'b1;
          end else begin
            w_state_nxt = ST_IDLE;
          end
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_main or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= ST_IDLE;
      r_settle_cnt <= 8'd0;
      r_ref_en     <= 2'b00;
      r_ref_leds   <= 8'h00;
    end else begin
      r_state <= w_state_nxt;
      if (w_restart) begin
        r_settle_cnt <= 8'd1;
        r_ref_en     <= r_en;
        r_ref_leds   <= r_leds;
      end else if (w_cnt_inc) begin
        r_settle_cnt <= r_settle_cnt + 8'd1;
      end
    end
  end

  assign w_cap_d0     = w_capture && (r_en == EN_DIGIT0);
  assign w_cap_d1     = w_capture && (r_en == EN_DIGIT1);
  assign w_got_nxt    = r_got | {w_cap_d1, w_cap_d0};
  assign w_frame_done = w_capture && (&w_got_nxt);
  assign w_relink     = w_en_valid && r_link_lost;
  assign w_nib0_new   = w_cap_d0 ? w_dec_nib : r_nib0;
  assign w_nib1_new   = w_cap_d1 ? w_dec_nib : r_nib1;

  always_ff @(posedge clk_main or negedge reset_n) begin
    if (!reset_n) begin
      r_got  <= 2'b00;
      r_nib0 <= 4'h0;
      r_nib1 <= 4'h0;
      r_derr <= 2'b00;
      r_ddp  <= 2'b00;
    end else begin
      if (w_cap_d0) begin
        r_nib0    <= w_dec_nib;
        r_derr[0] <= w_dec_err;
        r_ddp[0]  <= w_dp_lit;
      end
      if (w_cap_d1) begin
        r_nib1    <= w_dec_nib;
        r_derr[1] <= w_dec_err;
        r_ddp[1]  <= w_dp_lit;
      end
      if (w_relink || w_frame_done) r_got <= 2'b00;
      else                          r_got <= w_got_nxt;
    end
  end

  // A completed frame is loaded straight from this cycle's capture; if the
  // previous frame is still unaccepted the new one is dropped.
  always_ff @(posedge clk_main or negedge reset_n) begin
    if (!reset_n) begin
      r_valid    <= 1'b0;
      r_data     <= 8'h00;
      r_fdp      <= 2'b00;
      r_ferr     <= 2'b00;
      r_overflow <= 1'b0;
    end else if (w_frame_done) begin
      if (!r_valid || frame.frame_ready) begin
        r_valid <= 1'b1;
        r_data  <= {w_nib1_new, w_nib0_new};
        r_fdp   <= {w_cap_d1 ? w_dp_lit : r_ddp[1], w_cap_d0 ? w_dp_lit : r_ddp[0]};
        r_ferr  <= {w_cap_d1 ? w_dec_err : r_derr[1], w_cap_d0 ? w_dec_err : r_derr[0]};
      end else begin
        r_overflow <= 1'b1;
      end
    end else if (r_valid && frame.frame_ready) begin
      r_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk_main or negedge reset_n) begin
    if (!reset_n) begin
      r_to_cnt    <= 16'd0;
      r_link_lost <= 1'b0;
    end else if (w_en_valid) begin
      r_to_cnt    <= 16'd0;
      r_link_lost <= 1'b0;
    end else if (r_to_cnt != TIMEOUT_N) begin
      r_to_cnt    <= r_to_cnt + 16'd1;
      r_link_lost <= (r_to_cnt + 16'd1 == TIMEOUT_N);
    end
  end

`ifdef SEV_SEG_CAP_ERRCNT_EN
  logic [7:0] r_err_cnt;

  always_ff @(posedge clk_main or negedge reset_n) begin
    if (!reset_n) begin
      r_err_cnt <= 8'd0;
    end else if (w_capture && w_dec_err && (r_err_cnt != 8'hFF)) begin
      r_err_cnt <= r_err_cnt + 8'd1;
    end
  end

  assign err_count = r_err_cnt;
`endif

  assign frame.frame_valid = r_valid;
  assign frame.frame_data  = r_data;
  assign frame.frame_dp    = r_fdp;
  assign frame.decode_err  = r_ferr;
  assign overflow          = r_overflow;
  assign link_lost         = r_link_lost;
  assign dbg_state         = r_state;

endmodule

// File: tb/tb_sev_seg_capture.sv
// Bench for sev_seg_capture: directed frame vectors, multi-cycle corner
// sequences and randomized bus traffic checked against a run-length model.
module tb_sev_seg_capture;
  import sev_seg_pkg::*;

  localparam int TB_SETTLE  = 4;
  localparam int TB_TIMEOUT = 1024;

  logic       clk;
  logic       reset_n;
  logic [7:0] sev_seg_leds;
  logic [1:0] led_enable;
  logic       overflow;
  logic       link_lost;
  state_t     dbg_state;
`ifdef SEV_SEG_CAP_ERRCNT_EN
  logic [7:0] err_count;
`endif

  sev_seg_capture_if frame_if ();

  sev_seg_capture #(
    .SETTLE_CYCLES  (TB_SETTLE),
    .TIMEOUT_CYCLES (TB_TIMEOUT)
  ) dut (
    .clk_main     (clk),
    .reset_n      (reset_n),
    .sev_seg_leds (sev_seg_leds),
    .led_enable   (led_enable),
    .frame        (frame_if),
    .overflow     (overflow),
    .link_lost    (link_lost),
`ifdef SEV_SEG_CAP_ERRCNT_EN
    .err_count    (err_count),
`endif
    .dbg_state    (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %h required %h", name, act, exp);
    end
  endtask

  logic [14:0] outs;
  assign outs = {frame_if.frame_valid, frame_if.frame_data, frame_if.frame_dp,
                 frame_if.decode_err, overflow, link_lost};

  // reference model: works on run lengths of the registered (enable, pattern) pair
  logic [6:0] seg_tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                               7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  function automatic logic [4:0] ref_decode(input logic [6:0] pat);
    for (int k = 0; k < 16; k++)
      if (seg_tab[k] == pat) return {1'b0, 4'(k)};
    return 5'b1_0000;
  endfunction

  logic [1:0] m_en_d, m_prev_en;
  logic [7:0] m_leds_d;
  logic [9:0] m_prev_pair;
  int         m_run, m_to, m_errcnt, m_idx;
  logic       m_en_done, m_ev, m_cap, m_done, m_ll, m_valid, m_ovf;
  logic [1:0] m_got, m_derr, m_ddp, m_fdp, m_ferr;
  logic [3:0] m_nib [2];
  logic [7:0] m_data;
  logic [4:0] m_dec;
  logic       chk_on = 1'b0;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_en_d = 2'b00; m_leds_d = 8'h00; m_prev_en = 2'b00; m_prev_pair = 10'd0;
      m_run = 0; m_to = 0; m_errcnt = 0; m_en_done = 1'b0; m_ll = 1'b0;
      m_valid = 1'b0; m_ovf = 1'b0; m_got = 2'b00; m_derr = 2'b00; m_ddp = 2'b00;
      m_fdp = 2'b00; m_ferr = 2'b00; m_data = 8'h00; m_nib[0] = 4'h0; m_nib[1] = 4'h0;
    end else begin
      m_ev = (m_en_d == 2'b01) || (m_en_d == 2'b10);
      if (m_ev) begin
        if (m_ll) m_got = 2'b00;
        m_to = 0;
        m_ll = 1'b0;
      end else begin
        if (m_to < TB_TIMEOUT) m_to++;
        m_ll = (m_to == TB_TIMEOUT);
      end
      if (m_en_d != m_prev_en) m_en_done = 1'b0;
      if ({m_en_d, m_leds_d} == m_prev_pair) begin
        if (m_run < 1000) m_run++;
      end else begin
        m_run = 1;
      end
      m_prev_pair = {m_en_d, m_leds_d};
      m_prev_en   = m_en_d;
      m_cap = m_ev && !m_en_done && (m_run >= TB_SETTLE);
      m_done = 1'b0;
      if (m_cap) begin
        m_en_done = 1'b1;
        m_idx = (m_en_d == 2'b10) ? 1 : 0;
        m_dec = ref_decode(~m_leds_d[6:0]);
        m_nib[m_idx]  = m_dec[3:0];
        m_derr[m_idx] = m_dec[4];
        m_ddp[m_idx]  = ~m_leds_d[7];
        m_got[m_idx]  = 1'b1;
        if (m_dec[4] && m_errcnt < 255) m_errcnt++;
        m_done = (m_got == 2'b11);
      end
      if (m_done) begin
        m_got = 2'b00;
        if (!m_valid || frame_if.frame_ready) begin
          m_valid = 1'b1;
          m_data  = {m_nib[1], m_nib[0]};
          m_fdp   = m_ddp;
          m_ferr  = m_derr;
        end else begin
          m_ovf = 1'b1;
        end
      end else if (m_valid && frame_if.frame_ready) begin
        m_valid = 1'b0;
      end
      m_en_d   = led_enable;
      m_leds_d = sev_seg_leds;
    end
  end

  // scoreboard: compare every cycle away from the active edge
  always @(negedge clk) begin
    if (reset_n && chk_on) begin
      check("model_outs", {1'b0, outs}, {1'b0, m_valid, m_data, m_fdp, m_ferr, m_ovf, m_ll});
`ifdef SEV_SEG_CAP_ERRCNT_EN
      check("model_errcnt", {8'h00, err_count}, 16'(m_errcnt));
`endif
    end
  end

  // driver tasks
  task automatic drive(input logic [1:0] en, input logic [7:0] leds, input int n);
    led_enable   = en;
    sev_seg_leds = leds;
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_ready();
    frame_if.frame_ready = 1'b1;
    @(negedge clk);
    frame_if.frame_ready = 1'b0;
  endtask

  typedef struct {
    logic [7:0] leds0;
    logic [7:0] leds1;
    logic [7:0] exp_data;
    logic [1:0] exp_dp;
    logic [1:0] exp_err;
  } vec_t;

  localparam int NV = 7;
  vec_t tv [NV];
  int   r, hold, d;

  initial begin
    tv[0] = '{8'hF9, 8'h8E, 8'hF1, 2'b00, 2'b00};
    tv[1] = '{8'h40, 8'hA4, 8'h20, 2'b01, 2'b00};
    tv[2] = '{8'h12, 8'h06, 8'hE5, 2'b11, 2'b00};
    tv[3] = '{8'hFF, 8'hF9, 8'h10, 2'b00, 2'b01};
    tv[4] = '{8'h83, 8'h7F, 8'h0B, 2'b10, 2'b10};
    tv[5] = '{8'hC6, 8'hA1, 8'hDC, 2'b00, 2'b00};
    tv[6] = '{8'h90, 8'h78, 8'h79, 2'b10, 2'b00};

    reset_n = 1'b0;
    led_enable = 2'b00;
    sev_seg_leds = 8'hFF;
    frame_if.frame_ready = 1'b0;

    // reset held: outputs stay cleared whatever the bus does
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check("reset_outs", {1'b0, outs}, 16'h0000);
      led_enable   = 2'($urandom_range(0, 3));
      sev_seg_leds = 8'($urandom_range(0, 255));
      frame_if.frame_ready = 1'($urandom_range(0, 1));
    end
    led_enable = 2'b00;
    sev_seg_leds = 8'hFF;
    frame_if.frame_ready = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    chk_on  = 1'b1;
    @(negedge clk);
    check("idle_state", 16'(dbg_state), 16'(ST_IDLE));

    // table-driven frames
    for (int i = 0; i < NV; i++) begin
      drive(2'b01, tv[i].leds0, 4);
      drive(2'b10, tv[i].leds1, 4);
      drive(2'b00, 8'hFF, 2);
      check("vec_valid", 16'(frame_if.frame_valid), 16'h1);
      check("vec_data", 16'(frame_if.frame_data), 16'(tv[i].exp_data));
      check("vec_dp", 16'(frame_if.frame_dp), 16'(tv[i].exp_dp));
      check("vec_err", 16'(frame_if.decode_err), 16'(tv[i].exp_err));
      drive(2'b00, 8'hFF, 2);
      check("vec_hold", 16'({frame_if.frame_valid, frame_if.frame_data}), 16'({1'b1, tv[i].exp_data}));
      pulse_ready();
      check("vec_drop", 16'(frame_if.frame_valid), 16'h0);
    end
`ifdef SEV_SEG_CAP_ERRCNT_EN
    check("errcnt_table", 16'(err_count), 16'd2);
`endif

    // unstable pattern never captures; a lone digit_1 stays pending
    for (int k = 0; k < 8; k++) drive(2'b01, (k % 2 == 1) ? 8'h80 : 8'hC0, 2);
    drive(2'b00, 8'hFF, 3);
    check("glitch_noframe", 16'(frame_if.frame_valid), 16'h0);
    drive(2'b10, 8'hB0, 4);
    drive(2'b00, 8'hFF, 3);
    check("half_noframe", 16'(frame_if.frame_valid), 16'h0);
    drive(2'b01, 8'h99, 4);
    drive(2'b00, 8'hFF, 2);
    check("pending_pair", 16'({frame_if.frame_valid, frame_if.frame_data}), 16'h134);
    pulse_ready();

    // re-capture of digit_0 after a gap overwrites the older value
    drive(2'b01, 8'hF9, 4);
    drive(2'b00, 8'hFF, 2);
    drive(2'b01, 8'hA4, 4);
    drive(2'b10, 8'h92, 4);
    drive(2'b00, 8'hFF, 2);
    check("overwrite", 16'({frame_if.frame_valid, frame_if.frame_data}), 16'h152);
    pulse_ready();

    // pattern change without an enable change is ignored in HOLD
    drive(2'b01, 8'hF9, 4);
    drive(2'b01, 8'hA4, 4);
    drive(2'b10, 8'h92, 4);
    drive(2'b00, 8'hFF, 2);
    check("hold_ignore", 16'({frame_if.frame_valid, frame_if.frame_data}), 16'h151);
    pulse_ready();

    // overflow: second frame arrives while the first is unaccepted
    check("ovf_before", 16'(overflow), 16'h0);
    drive(2'b01, 8'h88, 4);
    drive(2'b10, 8'hB0, 4);
    drive(2'b00, 8'hFF, 2);
    drive(2'b01, 8'hF8, 4);
    drive(2'b10, 8'h80, 4);
    drive(2'b00, 8'hFF, 2);
    check("ovf_held", 16'({frame_if.frame_valid, frame_if.frame_data}), 16'h13A);
    check("ovf_flag", 16'(overflow), 16'h1);
    pulse_ready();
    check("ovf_drop", 16'(frame_if.frame_valid), 16'h0);
    drive(2'b00, 8'hFF, 3);
    check("ovf_sticky", 16'(overflow), 16'h1);

    // link loss discards the pending digit_0
    drive(2'b01, 8'h82, 4);
    drive(2'b00, 8'hFF, 1000);
    check("link_early", 16'(link_lost), 16'h0);
    drive(2'b00, 8'hFF, 40);
    check("link_lost", 16'(link_lost), 16'h1);
    drive(2'b10, 8'h90, 1);
    check("link_reg_delay", 16'(link_lost), 16'h1);
    drive(2'b10, 8'h90, 1);
    check("link_clear", 16'(link_lost), 16'h0);
    drive(2'b10, 8'h90, 2);
    drive(2'b00, 8'hFF, 3);
    check("link_flush", 16'(frame_if.frame_valid), 16'h0);
    drive(2'b01, 8'hA4, 4);
    drive(2'b00, 8'hFF, 2);
    check("link_frame", 16'({frame_if.frame_valid, frame_if.frame_data}), 16'h192);
    pulse_ready();

    // reset mid-frame discards the partial digit
    drive(2'b01, 8'hC0, 4);
    drive(2'b00, 8'hFF, 1);
    reset_n = 1'b0;
    @(negedge clk);
    check("midreset_outs", {1'b0, outs}, 16'h0000);
    reset_n = 1'b1;
    drive(2'b10, 8'hF9, 4);
    drive(2'b00, 8'hFF, 3);
    check("midreset_noframe", 16'(frame_if.frame_valid), 16'h0);

    // randomized traffic against the model
    for (int s = 0; s < 600; s++) begin
      r = $urandom_range(0, 9);
      led_enable = (r < 4) ? 2'b01 : (r < 8) ? 2'b10 : (r == 8) ? 2'b00 : 2'b11;
      if ($urandom_range(0, 4) != 0) begin
        d = $urandom_range(0, 15);
        sev_seg_leds = {1'($urandom_range(0, 1)), ~seg_tab[d]};
      end else begin
        sev_seg_leds = 8'($urandom_range(0, 255));
      end
      hold = $urandom_range(1, 8);
      for (int c = 0; c < hold; c++) begin
        frame_if.frame_ready = 1'($urandom_range(0, 1));
        @(negedge clk);
      end
    end
    frame_if.frame_ready = 1'b0;
    drive(2'b00, 8'hFF, 4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
